// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared definitions for the system bus arbiter and the address
//            translator: arbiter state encoding, arbitration mode constants,
//            fixed bus IDs and a width helper for master-index fields.
// Ports    : none (package)
// Revision : 1.0 - initial multi-master release
// ============================================================================
package bus_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // Arbitration modes
  localparam logic ARB_FIXED = 1'b0;  // highest index wins
  localparam logic ARB_RR    = 1'b1;  // round-robin from the pointer

  // Bus IDs, shared with the address translator
  localparam int BUS_ID_ROM = 0;
  localparam int BUS_ID_RAM = 1;
  localparam int BUS_ID_VGA = 2;
  localparam int BUS_ID_PS2 = 3;
  localparam int BUS_ID_ACP = 4;
  localparam int BUS_ID_CPU = 7;

  // Bits needed to hold an index 0..n-1, never less than one
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr_if
// Purpose  : Request/grant bundle between the bus masters and the arbiter.
// Signals  : req      - per-master request level
//            bus_wait - slave stall, high while a transfer is in flight
//            ack      - one-hot grant (or zero)
//            bus_busy - high while any ack is high
//            owner    - index of the current/last owner
//            timeout  - one-cycle pulse on watchdog revocation
// Modports : master - requester/bus side (drives req, bus_wait)
//            slave  - arbiter side (drives ack, bus_busy, owner, timeout)
// Revision : 1.0 - initial multi-master release
// ============================================================================
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 8
);
  localparam int c_id_w = bus_pkg::id_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic                   bus_wait;
  logic [NUM_MASTERS-1:0] ack;
  logic                   bus_busy;
  logic [c_id_w-1:0]      owner;
  logic                   timeout;

  modport master (
    output req, bus_wait,
    input  ack, bus_busy, owner, timeout
  );

  modport slave (
    input  req, bus_wait,
    output ack, bus_busy, owner, timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational winner selection for the bus arbiter.
//            Fixed mode picks the highest eligible index; round-robin mode
//            picks the first eligible index at or above ptr, wrapping to 0.
//            Masked requesters are never eligible.
// Ports    : req   - request vector
//            ptr   - round-robin start index
//            mask  - requesters excluded from selection
//            mode  - ARB_FIXED or ARB_RR
//            valid - at least one eligible requester
//            grant - one-hot winner (zero when !valid)
// Revision : 1.0 - initial multi-master release
// ============================================================================
module rr_pick
  import bus_pkg::*;
#(
  parameter  int NUM_MASTERS = 8,
  localparam int ID_W        = id_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic                   mode,
  output logic                   valid,
  output logic [NUM_MASTERS-1:0] grant
);

  logic [NUM_MASTERS-1:0] w_elig;
  logic                   w_found;

  assign w_elig = req & ~mask;
  assign valid  = |w_elig;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    if (mode == ARB_FIXED) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (!w_found && w_elig[i]) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end else begin
      // First pass covers ptr..N-1, second pass supplies the wrap to 0.
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!w_found && w_elig[i] && (i >= int'(ptr))) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!w_found && w_elig[i]) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Purpose  : N-master arbiter for the shared system bus. Grants one master
//            at a time (fixed priority or round-robin), holds the grant until
//            the owner drops req and the slave stops stalling, then keeps all
//            acks low for TURNAROUND cycles before the next owner.
// Ports    : clk     - system clock, rising edge
//            reset_L - asynchronous active-low reset
//            bus     - bus_arbiter_rr_if.slave (req, bus_wait in;
//                      ack, bus_busy, owner, timeout out)
// Options  : ARB_TIMEOUT_EN - enables the MAX_HOLD watchdog with per-master
//            masking; when undefined, timeout is constantly 0.
// Revision : 1.0 - initial multi-master release
// ============================================================================
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 8,
  parameter int ARB_MODE    = 0,
  parameter int TURNAROUND  = 1,
  parameter int MAX_HOLD    = 256
) (
  input logic             clk,
  input logic             reset_L,
  bus_arbiter_rr_if.slave bus
);

  localparam int c_id_w  = id_width(NUM_MASTERS);
  localparam int c_gap_w = id_width(TURNAROUND);

  if (TURNAROUND < 1) begin : g_bad_turnaround
    $error("bus_arbiter_rr: TURNAROUND must be at least 1");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_arbiter_rr: MAX_HOLD must be at least 1");
  end

  arb_state_t             r_state, w_state_n;
  logic [NUM_MASTERS-1:0] r_ack, w_ack_n;
  logic                   r_busy;
  logic [c_id_w-1:0]      r_owner, w_owner_n;
  logic [c_id_w-1:0]      r_ptr, w_ptr_n;
  logic [c_gap_w-1:0]     r_gap, w_gap_n;
  logic                   r_timeout, w_timeout_n;

  logic                   w_arb;
  logic                   w_valid;
  logic [NUM_MASTERS-1:0] w_win;
  logic [c_id_w-1:0]      w_win_idx;
  logic [NUM_MASTERS-1:0] w_mask;
  logic                   w_hold_exp;
  logic                   w_mode;

  assign w_mode = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req  (bus.req),
    .ptr  (r_ptr),
    .mask (w_mask),
    .mode (w_mode),
    .valid(w_valid),
    .grant(w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win[i]) w_win_idx = c_id_w'(i);
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_n   = r_state;
    w_ack_n     = r_ack;
    w_owner_n   = r_owner;
    w_ptr_n     = r_ptr;
    w_gap_n     = r_gap;
    w_timeout_n = 1'b0;
    w_arb       = 1'b0;

    unique case (r_state)
      ST_IDLE: w_arb = 1'b1;

      ST_GRANT: begin
        if (!bus.req[r_owner]) begin
          // A stall seen on the release edge wins: finish the transfer first.
          if (bus.bus_wait) begin
            w_state_n = ST_DRAIN;
          end else begin
            w_ack_n   = '0;
            w_gap_n   = '0;
            w_state_n = ST_GAP;
          end
        end else if (w_hold_exp && !bus.bus_wait) begin
          w_ack_n     = '0;
          w_gap_n     = '0;
          w_timeout_n = 1'b1;
          w_state_n   = ST_GAP;
        end
      end

      ST_DRAIN: begin
        if (!bus.bus_wait) begin
          w_ack_n   = '0;
          w_gap_n   = '0;
          w_state_n = ST_GAP;
        end
      end

      ST_GAP: begin
        if (r_gap == c_gap_w'(TURNAROUND - 1)) w_arb = 1'b1;
        else                                   w_gap_n = r_gap + 1'b1;
      end

      default: begin
        w_ack_n   = '0;
        w_state_n = ST_IDLE;
      end
    endcase

    if (w_arb) begin
      if (w_valid) begin
        w_state_n = ST_GRANT;
        w_ack_n   = w_win;
        w_owner_n = w_win_idx;
        w_ptr_n   = (w_win_idx == c_id_w'(NUM_MASTERS - 1)) ? '0 : w_win_idx + 1'b1;
      end else begin
        w_state_n = ST_IDLE;
        w_ack_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= ST_IDLE;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_gap     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ack     <= w_ack_n;
      r_busy    <= |w_ack_n;
      r_owner   <= w_owner_n;
      r_ptr     <= w_ptr_n;
      r_gap     <= w_gap_n;
      r_timeout <= w_timeout_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int c_hold_w = id_width(MAX_HOLD);

  logic [c_hold_w-1:0]    r_hold;
  logic [NUM_MASTERS-1:0] r_mask;

  // Counter saturates at MAX_HOLD-1, so the MAX_HOLD-th held cycle expires.
  assign w_hold_exp = (r_hold == c_hold_w'(MAX_HOLD - 1));
  assign w_mask     = r_mask;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_hold <= '0;
      r_mask <= '0;
    end else begin
      if (r_state == ST_GRANT || r_state == ST_DRAIN) begin
        if (!w_hold_exp) r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end
      // A revoked master stays masked until its req is sampled low;
      // r_ack is still the owner's one-hot on the revoking edge.
      r_mask <= (r_mask & bus.req) | (w_timeout_n ? r_ack : '0);
    end
  end
`else
  assign w_hold_exp = 1'b0;
  assign w_mask     = '0;
`endif

  assign bus.ack      = r_ack;
  assign bus.bus_busy = r_busy;
  assign bus.owner    = r_owner;
  assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Purpose  : Directed self-checking bench for bus_arbiter_rr. One instance in
//            fixed-priority mode (TURNAROUND=1, MAX_HOLD=16) and one in
//            round-robin mode (TURNAROUND=2).
// Options  : ARB_TIMEOUT_EN - selects the watchdog scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

  logic clk = 1'b0;
  logic reset_L;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #10 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(8)) fix_if ();
  bus_arbiter_rr_if #(.NUM_MASTERS(8)) rr_if ();

  bus_arbiter_rr #(
    .NUM_MASTERS(8), .ARB_MODE(0), .TURNAROUND(1), .MAX_HOLD(16)
  ) u_fix (
    .clk(clk), .reset_L(reset_L), .bus(fix_if)
  );

  bus_arbiter_rr #(
    .NUM_MASTERS(8), .ARB_MODE(1), .TURNAROUND(2), .MAX_HOLD(256)
  ) u_rr (
    .clk(clk), .reset_L(reset_L), .bus(rr_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    fix_if.req = '0; fix_if.bus_wait = 1'b0;
    rr_if.req  = '0; rr_if.bus_wait  = 1'b0;
    tick(); tick();
    n_checks++;
    if (fix_if.ack !== 8'h00 || fix_if.bus_busy !== 1'b0 || fix_if.owner !== 3'd0 || fix_if.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fix: ack=%h busy=%b owner=%0d to=%b, want 00/0/0/0", fix_if.ack, fix_if.bus_busy, fix_if.owner, fix_if.timeout);
    end
    n_checks++;
    if (rr_if.ack !== 8'h00 || rr_if.bus_busy !== 1'b0 || rr_if.owner !== 3'd0 || rr_if.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rr: ack=%h busy=%b owner=%0d to=%b, want 00/0/0/0", rr_if.ack, rr_if.bus_busy, rr_if.owner, rr_if.timeout);
    end
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_single();
    fix_if.req = 8'h80;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h80 || fix_if.bus_busy !== 1'b1 || fix_if.owner !== 3'd7) begin
      n_fail++;
      $display("FAIL single_grant: ack=%h busy=%b owner=%0d, want 80/1/7", fix_if.ack, fix_if.bus_busy, fix_if.owner);
    end
    repeat (5) tick();
    n_checks++;
    if (fix_if.ack !== 8'h80) begin
      n_fail++;
      $display("FAIL single_hold: ack=%h, want 80", fix_if.ack);
    end
    fix_if.req = 8'h00;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h00 || fix_if.bus_busy !== 1'b0 || fix_if.owner !== 3'd7) begin
      n_fail++;
      $display("FAIL single_release: ack=%h busy=%b owner=%0d, want 00/0/7", fix_if.ack, fix_if.bus_busy, fix_if.owner);
    end
    tick();
  endtask

  task automatic test_fixed_priority();
    fix_if.req = 8'h82;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h80 || fix_if.owner !== 3'd7) begin
      n_fail++;
      $display("FAIL fixed_win: ack=%h owner=%0d, want 80/7", fix_if.ack, fix_if.owner);
    end
    tick(); tick();
    fix_if.req = 8'h02;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h00 || fix_if.bus_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_gap: ack=%h busy=%b, want 00/0", fix_if.ack, fix_if.bus_busy);
    end
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h02 || fix_if.owner !== 3'd1) begin
      n_fail++;
      $display("FAIL fixed_second: ack=%h owner=%0d, want 02/1", fix_if.ack, fix_if.owner);
    end
    // Higher-priority request during a grant must not preempt the owner
    fix_if.req = 8'h82;
    tick(); tick();
    n_checks++;
    if (fix_if.ack !== 8'h02) begin
      n_fail++;
      $display("FAIL fixed_no_preempt: ack=%h, want 02", fix_if.ack);
    end
    fix_if.req = 8'h80;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h00) begin
      n_fail++;
      $display("FAIL fixed_release2: ack=%h, want 00", fix_if.ack);
    end
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h80) begin
      n_fail++;
      $display("FAIL fixed_third: ack=%h, want 80", fix_if.ack);
    end
    fix_if.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_drain();
    fix_if.req = 8'h04;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h04) begin
      n_fail++;
      $display("FAIL drain_grant: ack=%h, want 04", fix_if.ack);
    end
    // Owner releases on the same edge the slave starts stalling
    fix_if.req = 8'h00;
    fix_if.bus_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fix_if.ack !== 8'h04 || fix_if.bus_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_hold%0d: ack=%h busy=%b, want 04/1", i, fix_if.ack, fix_if.bus_busy);
      end
    end
    fix_if.bus_wait = 1'b0;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h00 || fix_if.bus_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_release: ack=%h busy=%b, want 00/0", fix_if.ack, fix_if.bus_busy);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int         order [5] = '{0, 1, 4, 0, 1};
    logic [7:0] want;
    rr_if.req = 8'h13;
    for (int k = 0; k < 5; k++) begin
      want = 8'h01 << order[k];
      tick();
      n_checks++;
      if (rr_if.ack !== want || rr_if.owner !== 3'(order[k])) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ack=%h owner=%0d, want %h/%0d", k, rr_if.ack, rr_if.owner, want, order[k]);
      end
      repeat (3) tick();
      n_checks++;
      if (rr_if.ack !== want) begin
        n_fail++;
        $display("FAIL rr_hold%0d: ack=%h, want %h", k, rr_if.ack, want);
      end
      rr_if.req = 8'h13 & ~want;
      tick();
      n_checks++;
      if (rr_if.ack !== 8'h00 || rr_if.bus_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap_a%0d: ack=%h busy=%b, want 00/0", k, rr_if.ack, rr_if.bus_busy);
      end
      rr_if.req = (k == 4) ? 8'h00 : 8'h13;
      tick();
      n_checks++;
      if (rr_if.ack !== 8'h00) begin
        n_fail++;
        $display("FAIL rr_gap_b%0d: ack=%h, want 00", k, rr_if.ack);
      end
    end
    tick();
    n_checks++;
    if (rr_if.ack !== 8'h00) begin
      n_fail++;
      $display("FAIL rr_idle: ack=%h, want 00", rr_if.ack);
    end
  endtask

  task automatic test_reset_mid();
    // ptr is 2 here, so master 4 wins and ptr moves to 5
    rr_if.req = 8'h10;
    tick();
    n_checks++;
    if (rr_if.ack !== 8'h10 || rr_if.owner !== 3'd4) begin
      n_fail++;
      $display("FAIL rst_mid_grant: ack=%h owner=%0d, want 10/4", rr_if.ack, rr_if.owner);
    end
    tick();
    #3 reset_L = 1'b0;
    #2;
    n_checks++;
    if (rr_if.ack !== 8'h00 || rr_if.owner !== 3'd0 || rr_if.bus_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: ack=%h owner=%0d busy=%b, want 00/0/0", rr_if.ack, rr_if.owner, rr_if.bus_busy);
    end
    tick();
    reset_L = 1'b1;
    // ptr back at 0 picks 4; a stale ptr of 5 would pick 5
    rr_if.req = 8'h30;
    tick();
    n_checks++;
    if (rr_if.ack !== 8'h10 || rr_if.owner !== 3'd4) begin
      n_fail++;
      $display("FAIL rst_mid_order: ack=%h owner=%0d, want 10/4", rr_if.ack, rr_if.owner);
    end
    rr_if.req = 8'h00;
    repeat (4) tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    fix_if.req = 8'h03;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h02) begin
      n_fail++;
      $display("FAIL to_grant: ack=%h, want 02", fix_if.ack);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (fix_if.ack !== 8'h02 || fix_if.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold%0d: ack=%h to=%b, want 02/0", i, fix_if.ack, fix_if.timeout);
      end
    end
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h00 || fix_if.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_revoke: ack=%h to=%b, want 00/1", fix_if.ack, fix_if.timeout);
    end
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h01 || fix_if.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_next: ack=%h to=%b, want 01/0", fix_if.ack, fix_if.timeout);
    end
    fix_if.req = 8'h02;
    tick(); tick();
    n_checks++;
    if (fix_if.ack !== 8'h00) begin
      n_fail++;
      $display("FAIL to_masked: ack=%h, want 00", fix_if.ack);
    end
    fix_if.req = 8'h00;
    tick();
    fix_if.req = 8'h02;
    tick();
    n_checks++;
    if (fix_if.ack !== 8'h02) begin
      n_fail++;
      $display("FAIL to_unmasked: ack=%h, want 02", fix_if.ack);
    end
    fix_if.req = 8'h00;
    tick(); tick();
  endtask
`else
  task automatic test_no_timeout();
    fix_if.req = 8'h02;
    tick();
    repeat (20) tick();
    n_checks++;
    if (fix_if.ack !== 8'h02) begin
      n_fail++;
      $display("FAIL long_hold: ack=%h, want 02", fix_if.ack);
    end
    n_checks++;
    if (fix_if.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_tied: to=%b, want 0", fix_if.timeout);
    end
    fix_if.req = 8'h00;
    tick(); tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_fixed_priority();
    test_drain();
    test_round_robin();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
